// File: rtl/frame_filler_if.sv
// frame_filler_if: fill-command handshake plus DDR address/write-data FIFO push ports
interface frame_filler_if;
    logic         valid;
    logic [23:0]  color;
    logic [31:0]  frame;
    logic         ready;
    logic         af_full;
    logic         af_wr_en;
    logic [30:0]  af_addr_din;
    logic         wdf_full;
    logic         wdf_wr_en;
    logic [127:0] wdf_data_din;
    logic [15:0]  wdf_mask_din;
    modport master (
        output valid, color, frame, af_full, wdf_full,
        input  ready, af_wr_en, af_addr_din, wdf_wr_en, wdf_data_din, wdf_mask_din
    );
    modport slave (
        input  valid, color, frame, af_full, wdf_full,
        output ready, af_wr_en, af_addr_din, wdf_wr_en, wdf_data_din, wdf_mask_din
    );
endinterface

// File: rtl/frame_filler.sv
// frame_filler: paints a whole frame buffer one colour with 8-pixel DDR write bursts
module frame_filler #(
    parameter int WIDTH  = 800,
    parameter int HEIGHT = 600
) (
    input logic           clk,
    input logic           rst,
    frame_filler_if.slave bus
);
    localparam logic [6:0] BX_LAST = 7'(WIDTH / 8 - 1);
    localparam logic [9:0] Y_LAST  = 10'(HEIGHT - 1);
    typedef enum logic [1:0] {IDLE, WR1, WR2, DONE} state_t;
    state_t      state;
    logic [23:0] color_q;
    logic [5:0]  frame_q;
    logic [6:0]  bx;
    logic [9:0]  y;
    logic        last;
    assign last = bx == BX_LAST && y == Y_LAST;
    // fill sequencer: two cycles per burst, x tracked as burst index (x = bx*8)
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            color_q <= '0;
            frame_q <= '0;
            bx      <= '0;
            y       <= '0;
        end else begin
            case (state)
                IDLE: if (bus.valid) begin
                    color_q <= bus.color;
                    frame_q <= bus.frame[27:22];
                    bx      <= '0;
                    y       <= '0;
                    state   <= WR1;
                end
                WR1: if (!bus.af_full && !bus.wdf_full) state <= WR2;
                WR2: if (!bus.wdf_full) begin
                    if (last) state <= DONE;
                    else begin
                        state <= WR1;
                        bx    <= bx == BX_LAST ? 7'd0 : bx + 7'd1;
                        y     <= bx == BX_LAST ? y + 10'd1 : y;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    // FIFO strobes follow state and backpressure; address and first data word always pushed together
    always_comb begin
        bus.ready        = state == IDLE;
        bus.af_wr_en     = state == WR1 && !bus.af_full && !bus.wdf_full;
        bus.wdf_wr_en    = bus.af_wr_en || (state == WR2 && !bus.wdf_full);
        bus.af_addr_din  = {6'b0, frame_q, y, bx, 2'b00};
        bus.wdf_data_din = {4{8'h00, color_q}};
        bus.wdf_mask_din = 16'h0000;
    end
endmodule

// File: tb/tb_frame_filler.sv
// tb_frame_filler: directed vectors and corner sequences for frame_filler on a reduced 64x4 frame
module tb_frame_filler;
    localparam int W = 64;
    localparam int H = 4;
    localparam int BURSTS = (W / 8) * H;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    int af_cnt = 0;
    int wdf_cnt = 0;
    int bad_data = 0;
    int viol = 0;
    logic [30:0] last_addr = '0;
    logic [127:0] exp_data = '0;
    frame_filler_if bus();
    frame_filler #(.WIDTH(W), .HEIGHT(H)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // push monitor: samples mid-cycle, each strobe seen here is consumed at the next rising edge
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.af_wr_en) begin
                af_cnt    = af_cnt + 1;
                last_addr = bus.af_addr_din;
                if (!bus.wdf_wr_en) viol = viol + 1;
            end
            if ((bus.af_wr_en && bus.af_full) || (bus.wdf_wr_en && bus.wdf_full)) viol = viol + 1;
            if (bus.wdf_wr_en) begin
                wdf_cnt = wdf_cnt + 1;
                if (bus.wdf_data_din !== exp_data || bus.wdf_mask_din !== 16'h0000) bad_data = bad_data + 1;
            end
        end
    end
    typedef struct {
        logic [23:0]  color;
        logic [31:0]  frame;
        logic [30:0]  addr0;
        logic [30:0]  addr1;
        logic [127:0] data;
    } vec_t;
    vec_t vecs[4];
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 128'(bus.ready), 128'd1);
        chk({tag, "_af_wr_en"}, 128'(bus.af_wr_en), 128'd0);
        chk({tag, "_wdf_wr_en"}, 128'(bus.wdf_wr_en), 128'd0);
        chk({tag, "_addr"}, 128'(bus.af_addr_din), 128'd0);
        chk({tag, "_data"}, bus.wdf_data_din, 128'd0);
        chk({tag, "_mask"}, 128'(bus.wdf_mask_din), 128'd0);
    endtask
    int n, af0, wdf0, bad0, viol0;
    initial begin
        vecs[0] = '{24'hABCDEF, 32'h10400000, 31'h00080000, 31'h00080004, {4{32'h00ABCDEF}}};
        vecs[1] = '{24'h123456, 32'hFFFFFFFF, 31'h01F80000, 31'h01F80004, {4{32'h00123456}}};
        vecs[2] = '{24'h000001, 32'hF03FFFFF, 31'h00000000, 31'h00000004, {4{32'h00000001}}};
        vecs[3] = '{24'hFFFFFF, 32'h00800000, 31'h00100000, 31'h00100004, {4{32'h00FFFFFF}}};
        rst = 1'b1;
        bus.valid = 1'b0;
        bus.color = '0;
        bus.frame = '0;
        bus.af_full = 1'b0;
        bus.wdf_full = 1'b0;
        repeat (10) tick();
        chk_idle("reset");
        rst = 1'b0;
        tick();
        chk_idle("post_reset");
        for (int i = 0; i < 4; i++) begin
            exp_data  = vecs[i].data;
            bus.valid = 1'b1;
            bus.color = vecs[i].color;
            bus.frame = vecs[i].frame;
            tick();
            bus.valid = 1'b0;
            bus.color = '0;
            bus.frame = '0;
            chk($sformatf("v%0d_ready_low", i), 128'(bus.ready), 128'd0);
            chk($sformatf("v%0d_wr1_af", i), 128'(bus.af_wr_en), 128'd1);
            chk($sformatf("v%0d_wr1_wdf", i), 128'(bus.wdf_wr_en), 128'd1);
            chk($sformatf("v%0d_addr0", i), 128'(bus.af_addr_din), 128'(vecs[i].addr0));
            chk($sformatf("v%0d_data", i), bus.wdf_data_din, vecs[i].data);
            chk($sformatf("v%0d_mask", i), 128'(bus.wdf_mask_din), 128'd0);
            tick();
            chk($sformatf("v%0d_wr2_af", i), 128'(bus.af_wr_en), 128'd0);
            chk($sformatf("v%0d_wr2_wdf", i), 128'(bus.wdf_wr_en), 128'd1);
            tick();
            chk($sformatf("v%0d_addr1", i), 128'(bus.af_addr_din), 128'(vecs[i].addr1));
            chk($sformatf("v%0d_wr1b_af", i), 128'(bus.af_wr_en), 128'd1);
            rst = 1'b1;
            tick();
            chk_idle($sformatf("v%0d_midfill_reset", i));
            rst = 1'b0;
            tick();
        end
        exp_data = {4{32'h00ABCDEF}};
        af0  = af_cnt;
        wdf0 = wdf_cnt;
        bad0 = bad_data;
        viol0 = viol;
        bus.valid = 1'b1;
        bus.color = 24'hABCDEF;
        bus.frame = 32'h10400000;
        tick();
        n = 1;
        while (!bus.ready && n < 1000) begin
            bus.valid = n == 10;
            bus.color = n == 10 ? 24'h123456 : 24'hABCDEF;
            tick();
            n++;
        end
        bus.valid = 1'b0;
        chk("fill_latency", 128'(n), 128'(2 * BURSTS + 2));
        chk("fill_af_pushes", 128'(af_cnt - af0), 128'(BURSTS));
        chk("fill_wdf_pushes", 128'(wdf_cnt - wdf0), 128'(2 * BURSTS));
        chk("fill_last_addr", 128'(last_addr), 128'h0008061C);
        chk("fill_bad_data", 128'(bad_data - bad0), 128'd0);
        chk("fill_violations", 128'(viol - viol0), 128'd0);
        repeat (3) tick();
        chk("no_queued_cmd_ready", 128'(bus.ready), 128'd1);
        chk("no_queued_cmd_af", 128'(bus.af_wr_en), 128'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        af0  = af_cnt;
        wdf0 = wdf_cnt;
        viol0 = viol;
        bus.af_full = 1'b1;
        bus.valid = 1'b1;
        tick();
        bus.valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("af_full_%0d_af", k), 128'(bus.af_wr_en), 128'd0);
            chk($sformatf("af_full_%0d_wdf", k), 128'(bus.wdf_wr_en), 128'd0);
            chk($sformatf("af_full_%0d_addr", k), 128'(bus.af_addr_din), 128'h00080000);
            tick();
        end
        bus.af_full = 1'b0;
        #1;
        chk("af_release_af", 128'(bus.af_wr_en), 128'd1);
        chk("af_release_wdf", 128'(bus.wdf_wr_en), 128'd1);
        chk("af_release_addr", 128'(bus.af_addr_din), 128'h00080000);
        tick();
        bus.wdf_full = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("wdf_full_%0d_wdf", k), 128'(bus.wdf_wr_en), 128'd0);
            chk($sformatf("wdf_full_%0d_af", k), 128'(bus.af_wr_en), 128'd0);
            chk($sformatf("wdf_full_%0d_addr", k), 128'(bus.af_addr_din), 128'h00080000);
            tick();
        end
        bus.wdf_full = 1'b0;
        #1;
        chk("wdf_release_wdf", 128'(bus.wdf_wr_en), 128'd1);
        chk("wdf_release_af", 128'(bus.af_wr_en), 128'd0);
        tick();
        chk("next_burst_af", 128'(bus.af_wr_en), 128'd1);
        chk("next_burst_addr", 128'(bus.af_addr_din), 128'h00080004);
        chk("stall_af_pushes", 128'(af_cnt - af0), 128'd1);
        chk("stall_wdf_pushes", 128'(wdf_cnt - wdf0), 128'd2);
        chk("stall_violations", 128'(viol - viol0), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
